// File: rtl/vrf_bank_arbiter.sv
// vrf_bank_arbiter
// ----------------
// Per-lane arbiter between the read requesters (operand queues) and the
// write requesters (write-back units) for the single-port banks of a lane's
// VRF slice. Each cycle every request address is split into bank id (low
// bits) and in-bank address (high bits). At most one access is granted per
// bank, and the bank SRAM ports are driven from the winner.
//
// Writes normally beat reads. A per-bank starvation counter hands the bank
// to the read side once reads have lost to writes MaxWait cycles in a row.
// Within a side, a per-bank round-robin pointer picks the winner.
//
// Read data returns one cycle after the grant, routed from the bank the
// reader was granted on.
//
// Ports:
//   clk_i, rst_i                   clock, synchronous active-high reset
//   rd_valid_i / rd_addr_i         read requests (per read requester)
//   rd_ready_o                     read grant, same cycle
//   rd_rvalid_o / rd_rdata_o       read return, one cycle after grant
//   wr_valid_i / wr_addr_i         write requests (per write requester)
//   wr_data_i / wr_strb_i          write data and byte enables
//   wr_ready_o                     write grant, same cycle
//   bank_req_o / bank_we_o         per-bank access enable / write enable
//   bank_addr_o                    per-bank in-bank address
//   bank_wdata_o / bank_strb_o     per-bank write data / strobes
//   bank_rdata_i                   per-bank read data, one cycle after read

module vrf_bank_arbiter #(
    parameter int NrReadReq  = 3,
    parameter int NrWriteReq = 2,
    parameter int NrBank     = 8,
    parameter int MaxWait    = 4,
    parameter int AddrWidth  = 8,
    parameter int DataWidth  = 64,
    localparam int StrbWidth = DataWidth / 8,
    localparam int BankIdW   = $clog2(NrBank),
    localparam int BankAddrW = AddrWidth - BankIdW
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NrReadReq-1:0]                  rd_valid_i,
    input  logic [NrReadReq-1:0][AddrWidth-1:0]   rd_addr_i,
    output logic [NrReadReq-1:0]                  rd_ready_o,
    output logic [NrReadReq-1:0]                  rd_rvalid_o,
    output logic [NrReadReq-1:0][DataWidth-1:0]   rd_rdata_o,
    input  logic [NrWriteReq-1:0]                 wr_valid_i,
    input  logic [NrWriteReq-1:0][AddrWidth-1:0]  wr_addr_i,
    input  logic [NrWriteReq-1:0][DataWidth-1:0]  wr_data_i,
    input  logic [NrWriteReq-1:0][StrbWidth-1:0]  wr_strb_i,
    output logic [NrWriteReq-1:0]                 wr_ready_o,
    output logic [NrBank-1:0]                     bank_req_o,
    output logic [NrBank-1:0]                     bank_we_o,
    output logic [NrBank-1:0][BankAddrW-1:0]      bank_addr_o,
    output logic [NrBank-1:0][DataWidth-1:0]      bank_wdata_o,
    output logic [NrBank-1:0][StrbWidth-1:0]      bank_strb_o,
    input  logic [NrBank-1:0][DataWidth-1:0]      bank_rdata_i
);

    localparam int RdPtrW  = (NrReadReq  > 1) ? $clog2(NrReadReq)  : 1;
    localparam int WrPtrW  = (NrWriteReq > 1) ? $clog2(NrWriteReq) : 1;
    localparam int StarveW = $clog2(MaxWait + 1);

    // Per-bank grant vectors, OR-reduced into the requester-facing readies.
    logic [NrBank-1:0][NrReadReq-1:0]  rd_gnt;
    logic [NrBank-1:0][NrWriteReq-1:0] wr_gnt;

    genvar gi;
    generate
        for (gi = 0; gi < NrBank; gi++) begin : g_bank
            logic [NrReadReq-1:0]  rd_cand;
            logic [NrWriteReq-1:0] wr_cand;
            logic                  rd_any;
            logic                  wr_any;
            logic                  starved;
            logic                  wr_side;
            logic                  rd_side;
            logic                  rd_found;
            logic                  wr_found;
            logic [RdPtrW-1:0]     rd_win;
            logic [WrPtrW-1:0]     wr_win;
            logic [RdPtrW-1:0]     rd_ptr_reg;
            logic [RdPtrW-1:0]     rd_ptr_next;
            logic [WrPtrW-1:0]     wr_ptr_reg;
            logic [WrPtrW-1:0]     wr_ptr_next;
            logic [StarveW-1:0]    starve_cnt_reg;
            logic [StarveW-1:0]    starve_cnt_next;
            logic [NrReadReq-1:0]  rd_gnt_b;
            logic [NrWriteReq-1:0] wr_gnt_b;
            logic                  req_b;
            logic                  we_b;
            logic [BankAddrW-1:0]  addr_b;
            logic [DataWidth-1:0]  wdata_b;
            logic [StrbWidth-1:0]  strb_b;

            // Candidates are masked by reset so every combinational output
            // is quiet while rst_i is high.
            always_comb begin
                for (int r = 0; r < NrReadReq; r++) begin
                    rd_cand[r] = rd_valid_i[r] && !rst_i &&
                                 (rd_addr_i[r][BankIdW-1:0] == BankIdW'(gi));
                end
                for (int w = 0; w < NrWriteReq; w++) begin
                    wr_cand[w] = wr_valid_i[w] && !rst_i &&
                                 (wr_addr_i[w][BankIdW-1:0] == BankIdW'(gi));
                end
            end

            assign rd_any  = |rd_cand;
            assign wr_any  = |wr_cand;
            assign starved = (starve_cnt_reg == StarveW'(MaxWait));
            assign wr_side = wr_any && !(starved && rd_any);
            assign rd_side = rd_any && !wr_side;

            // Round robin: first candidate at or after the pointer.
            always_comb begin
                rd_found = 1'b0;
                rd_win   = rd_ptr_reg;
                for (int k = 0; k < NrReadReq; k++) begin
                    if (!rd_found && rd_cand[(int'(rd_ptr_reg) + k) % NrReadReq]) begin
                        rd_found = 1'b1;
                        rd_win   = RdPtrW'((int'(rd_ptr_reg) + k) % NrReadReq);
                    end
                end
                wr_found = 1'b0;
                wr_win   = wr_ptr_reg;
                for (int k = 0; k < NrWriteReq; k++) begin
                    if (!wr_found && wr_cand[(int'(wr_ptr_reg) + k) % NrWriteReq]) begin
                        wr_found = 1'b1;
                        wr_win   = WrPtrW'((int'(wr_ptr_reg) + k) % NrWriteReq);
                    end
                end
            end

            always_comb begin
                rd_gnt_b = '0;
                wr_gnt_b = '0;
                req_b    = 1'b0;
                we_b     = 1'b0;
                addr_b   = '0;
                wdata_b  = '0;
                strb_b   = '0;
                if (wr_side) begin
                    wr_gnt_b[wr_win] = 1'b1;
                    req_b   = 1'b1;
                    we_b    = 1'b1;
                    addr_b  = wr_addr_i[wr_win][AddrWidth-1:BankIdW];
                    wdata_b = wr_data_i[wr_win];
                    strb_b  = wr_strb_i[wr_win];
                end else if (rd_side) begin
                    rd_gnt_b[rd_win] = 1'b1;
                    req_b  = 1'b1;
                    addr_b = rd_addr_i[rd_win][AddrWidth-1:BankIdW];
                end
            end

            always_comb begin
                rd_ptr_next = rd_side ? RdPtrW'((int'(rd_win) + 1) % NrReadReq) : rd_ptr_reg;
                wr_ptr_next = wr_side ? WrPtrW'((int'(wr_win) + 1) % NrWriteReq) : wr_ptr_reg;
                // Count only cycles where a reader was actually held off by
                // a write; any other cycle resets the streak.
                if (rd_any && wr_side) begin
                    starve_cnt_next = starved ? starve_cnt_reg : starve_cnt_reg + 1'b1;
                end else begin
                    starve_cnt_next = '0;
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    rd_ptr_reg     <= '0;
                    wr_ptr_reg     <= '0;
                    starve_cnt_reg <= '0;
                end else begin
                    rd_ptr_reg     <= rd_ptr_next;
                    wr_ptr_reg     <= wr_ptr_next;
                    starve_cnt_reg <= starve_cnt_next;
                end
            end

            assign rd_gnt[gi]       = rd_gnt_b;
            assign wr_gnt[gi]       = wr_gnt_b;
            assign bank_req_o[gi]   = req_b;
            assign bank_we_o[gi]    = we_b;
            assign bank_addr_o[gi]  = addr_b;
            assign bank_wdata_o[gi] = wdata_b;
            assign bank_strb_o[gi]  = strb_b;
        end
    endgenerate

    // Each requester maps to exactly one bank, so the OR never merges two
    // grants for the same requester.
    always_comb begin
        rd_ready_o = '0;
        wr_ready_o = '0;
        for (int b = 0; b < NrBank; b++) begin
            rd_ready_o = rd_ready_o | rd_gnt[b];
            wr_ready_o = wr_ready_o | wr_gnt[b];
        end
    end

    // Read return: remember which bank each granted reader was served by.
    logic [NrReadReq-1:0]              rvalid_reg;
    logic [NrReadReq-1:0][BankIdW-1:0] rbank_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_reg <= '0;
            rbank_reg  <= '0;
        end else begin
            rvalid_reg <= rd_ready_o;
            for (int r = 0; r < NrReadReq; r++) begin
                rbank_reg[r] <= rd_addr_i[r][BankIdW-1:0];
            end
        end
    end

    // Masking with rst_i discards a return whose grant preceded the reset.
    always_comb begin
        for (int r = 0; r < NrReadReq; r++) begin
            rd_rvalid_o[r] = rvalid_reg[r] && !rst_i;
            rd_rdata_o[r]  = rd_rvalid_o[r] ? bank_rdata_i[rbank_reg[r]] : '0;
        end
    end

endmodule

// File: doc/vrf_bank_arbiter.md
# vrf_bank_arbiter

Per-lane arbiter between the operand queues (ALUA, ALUB, StoreOp) and the write-back units (WB_VALU, WB_VLU) for the NrBank single-port banks of the lane's VRF slice. Each cycle it maps every request's VRF word address to a bank, grants at most one access per bank, and drives the bank SRAM ports. It returns read data to the granted requester one cycle later. Writes normally take priority over reads, and a starvation counter bounds how long a read can be held off by writes.

## Interface
Parameters:
- NrReadReq, default NrOpQueue (3): read requesters, indexed by op_queue_e.
- NrWriteReq, default NrWriteBackVFU (2): write requesters, indexed by wb_vfu_e.
- NrBank, default core_pkg::NrBank (8): power of 2.
- MaxWait, default 4: consecutive write-caused losses after which a bank's read side gets priority.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- rd_valid_i  in  NrReadReq  read request valid.
- rd_addr_i  in  NrReadReq x vrf_addr_t  read word address.
- rd_ready_o  out  NrReadReq  read grant, same cycle.
- rd_rvalid_o  out  NrReadReq  read data valid, one cycle after grant.
- rd_rdata_o  out  NrReadReq x vrf_data_t  read data.
- wr_valid_i  in  NrWriteReq  write request valid.
- wr_addr_i  in  NrWriteReq x vrf_addr_t  write word address.
- wr_data_i  in  NrWriteReq x vrf_data_t  write data.
- wr_strb_i  in  NrWriteReq x vrf_strb_t  byte enables.
- wr_ready_o  out  NrWriteReq  write grant, same cycle.
- bank_req_o  out  NrBank  bank access enable.
- bank_we_o  out  NrBank  1 = write.
- bank_addr_o  out  NrBank x bank_addr_t  in-bank address.
- bank_wdata_o  out  NrBank x vrf_data_t  write data.
- bank_strb_o  out  NrBank x vrf_strb_t  write strobes.
- bank_rdata_i  in  NrBank x vrf_data_t  read data, valid one cycle after a read access.

## Operation
- Address split: bank_id = addr[log2(NrBank)-1:0]; bank_addr = addr >> log2(NrBank). With defaults, vrf_addr_t is 8 bits, bank_id is 3 bits and bank_addr is 5 bits.
- Per bank, each cycle:
  - Candidate writers are those with wr_valid_i set whose bank_id matches; candidate readers likewise.
  - Winning side: writes win if any writer is a candidate, unless the bank's starve_cnt equals MaxWait and at least one reader is a candidate. In that case reads win.
  - Within the winning side, round-robin arbitration. Each bank keeps one read pointer (log2 NrReadReq bits) and one write pointer. The pointer starts at its value and is set to winner+1 (mod N) after a grant.
- starve_cnt (per bank, saturating at MaxWait):
  - Increments when at least one reader is a candidate but the writes win.
  - Clears when the reads win or when no reader is a candidate.
- Grants: rd_ready_o[r] / wr_ready_o[w] are asserted only for winners. At most one grant per bank. A requester never receives more than one grant.
- Bank drive:
  - For a granted write: bank_req=1, bank_we=1, with addr/wdata/strb taken from the winner.
  - For a granted read: bank_req=1, bank_we=0, strb=0.
  - An idle bank drives bank_req=0 and all of its other fields to 0.
- Read return:
  - The grant registers a valid bit and the bank_id for each reader.
  - Next cycle, rd_rvalid_o[r] = registered valid and rd_rdata_o[r] = bank_rdata_i[registered bank_id]. rd_rdata_o is 0 when rd_rvalid_o is 0.
- Requesters hold valid/addr/data stable until granted. The arbiter never drops a granted request.

## Timing
- Grant is combinational from valid and address in the same cycle. Pointer and counter updates take effect at the next edge.
- Read latency is exactly 1 cycle from grant to rd_rvalid_o. A reader may be granted back-to-back and receive data every cycle.
- Write commit happens at the edge of the grant cycle. A read of the same address in a later cycle returns the new data. In the same cycle, the write wins (or the read wins via starvation) and the read returns the old data.
- Reset values: rd_rvalid_o=0, rd_rdata_o=0, all pointers=0, all starve_cnt=0. Combinational outputs are 0 while rst_i=1.
- Reset mid-operation: an outstanding read return is discarded, so rd_rvalid_o=0 in the cycle after rst_i.
- Simultaneous events:
  - Requests to different banks are all granted in the same cycle.
  - A starvation override on one bank does not affect other banks.

## Test plan
- All 3 readers hit banks 0, 1, 2 (addr 0x00, 0x09, 0x12), no writers -> all rd_ready_o=1; next cycle rd_rvalid_o=3'b111 with data from bank_rdata_i[0], [1], [2].
- ALUA, ALUB and StoreOp all read bank 3, held valid for 3 cycles -> grants in the order ALUA, ALUB, StoreOp, one per cycle; bank_addr_o[3] tracks each winner's addr>>3.
- WB_VALU and WB_VLU write bank 5 continuously -> grants alternate VALU, VLU, VALU.
- WB_VALU writes bank 2 every cycle while ALUB reads bank 2 -> ALUB loses for 4 cycles, wins on the 5th cycle, and starve_cnt clears.
- Write 0xDEADBEEF_0000_1111 with strb=8'h0F to addr 0x1C, then read 0x1C -> the read returns the new lower bytes; the same-cycle read/write returns the old data.
- Grant a read, assert rst_i in the next cycle -> rd_rvalid_o stays 0 and all ready outputs are 0 during reset.
